seq_bit_serializer: RTL and testbench

Upstream feeder for the 1011 sequence detector. Accepts parallel words on a valid/ready handshake and buffers them in a small FIFO. Shifts each word out MSB-first, one bit per clock, on ser_bit, which drives the detector's inp_bit directly. Back-to-back words stream with no gap bits; when no data is available, a fixed idle bit is emitted.

---
 rtl/seq_bit_serializer.sv | 165 ++++++++++++++++
 tb/tb_seq_bit_serializer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the 1011 detector: small FIFO, MSB-first gapless shifter.
// Optional even-parity bit after each word when SER_PARITY_EN is defined.
module seq_bit_serializer #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 4,
    parameter bit          IDLE_BIT = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       ser_bit,
    output logic                       ser_active,
    output logic                       word_done,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = AW + 1;
    localparam int unsigned CNTW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT
`ifdef SER_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             ser_bit_q, ser_bit_d;
    logic             active_q, active_d;
    logic             done_q, done_d;
    logic             push_c, pop_c, word_end_c;
    logic [WIDTH-1:0] head_c;
`ifdef SER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign in_ready = !reset && (count_q < CW'(DEPTH));
    assign push_c   = in_valid && in_ready;
    assign head_c   = mem_q[rd_ptr_q];

    // FIFO storage; not reset, validity is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            ser_bit_q <= IDLE_BIT;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
`ifdef SER_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            ser_bit_q <= ser_bit_d;
            active_q  <= active_d;
            done_q    <= done_d;
`ifdef SER_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        ser_bit_d  = ser_bit_q;
        active_d   = active_q;
        done_d     = 1'b0;
        pop_c      = 1'b0;
        word_end_c = 1'b0;
`ifdef SER_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            S_IDLE: word_end_c = 1'b1;
            S_SHIFT: begin
                if (cnt_q != '0) begin
                    ser_bit_d = shift_q[WIDTH-1];
                    shift_d   = {shift_q[WIDTH-2:0], 1'b0};
                    cnt_d     = cnt_q - CNTW'(1);
`ifndef SER_PARITY_EN
                    done_d    = (cnt_q == CNTW'(1));
`endif
                end else begin
`ifdef SER_PARITY_EN
                    ser_bit_d = parity_q;
                    done_d    = 1'b1;
                    state_d   = S_PARITY;
`else
                    word_end_c = 1'b1;
`endif
                end
            end
`ifdef SER_PARITY_EN
            S_PARITY: word_end_c = 1'b1;
`endif
            default: state_d = S_IDLE;
        endcase

        // End of a word (or idle): load the next word gaplessly, else emit the idle bit
        if (word_end_c) begin
            if (count_q != '0) begin
                pop_c     = 1'b1;
                ser_bit_d = head_c[WIDTH-1];
                shift_d   = {head_c[WIDTH-2:0], 1'b0};
                cnt_d     = CNTW'(WIDTH - 1);
                active_d  = 1'b1;
                state_d   = S_SHIFT;
`ifdef SER_PARITY_EN
                parity_d  = ^head_c;
`endif
            end else begin
                ser_bit_d = IDLE_BIT;
                active_d  = 1'b0;
                state_d   = S_IDLE;
            end
        end
    end

    assign ser_bit    = ser_bit_q;
    assign ser_active = active_q;
    assign word_done  = done_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: queue-based bit-stream reference model, directed and random stimulus.
module tb_seq_bit_serializer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
`ifdef SER_PARITY_EN
    localparam int unsigned PAR = 1;
`else
    localparam int unsigned PAR = 0;
`endif
    localparam int unsigned BPW = WIDTH + PAR;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_bit;
    logic             ser_active;
    logic             word_done;
    logic [CW-1:0]    fifo_count;

    logic             in_ready1, ser_bit1, ser_active1, word_done1;
    logic [CW-1:0]    fifo_count1;

    int n_tests = 0;
    int n_fail  = 0;

    seq_bit_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDLE_BIT(1'b0)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ser_bit    (ser_bit),
        .ser_active (ser_active),
        .word_done  (word_done),
        .fifo_count (fifo_count)
    );

    // Second instance with IDLE_BIT=1, never fed any data
    seq_bit_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDLE_BIT(1'b1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .in_data    ('0),
        .in_valid   (1'b0),
        .in_ready   (in_ready1),
        .ser_bit    (ser_bit1),
        .ser_active (ser_active1),
        .word_done  (word_done1),
        .fifo_count (fifo_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending words, and the remaining bits of the word on the line
    logic [WIDTH-1:0] m_fifo [$];
    logic             m_bits [$];
    logic             m_bit    = 1'b0;
    logic             m_active = 1'b0;
    logic             m_done   = 1'b0;
    logic             m_acc    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic v, input logic [WIDTH-1:0] d);
        int pre;
        logic [WIDTH-1:0] w;
        if (rst) begin
            m_fifo.delete();
            m_bits.delete();
            m_bit = 1'b0; m_active = 1'b0; m_done = 1'b0; m_acc = 1'b0;
            return;
        end
        pre   = m_fifo.size();
        m_acc = v && (pre < DEPTH);
        if (m_active && m_bits.size() > 0) begin
            m_bit  = m_bits.pop_front();
            m_done = (m_bits.size() == 0);
        end else if (pre > 0) begin
            w = m_fifo.pop_front();
            for (int i = WIDTH - 1; i >= 0; i--) m_bits.push_back(w[i]);
            if (PAR != 0) m_bits.push_back(^w);
            m_bit    = m_bits.pop_front();
            m_active = 1'b1;
            m_done   = (m_bits.size() == 0);
        end else begin
            m_bit = 1'b0; m_active = 1'b0; m_done = 1'b0;
        end
        if (m_acc) m_fifo.push_back(d);
    endtask

    task automatic step(input logic rst, input logic v, input logic [WIDTH-1:0] d);
        reset = rst; in_valid = v; in_data = d;
        #1;
        check("in_ready", 32'(in_ready), 32'(!rst && (m_fifo.size() < DEPTH)));
        @(posedge clk);
        model_edge(rst, v, d);
        @(negedge clk);
        check("ser_bit",     32'(ser_bit),    32'(m_bit));
        check("ser_active",  32'(ser_active), 32'(m_active));
        check("word_done",   32'(word_done),  32'(m_done));
        check("fifo_count",  32'(fifo_count), 32'(m_fifo.size()));
        check("idle1_bit",   32'(ser_bit1),    32'(1));
        check("idle1_active", 32'(ser_active1), 32'(0));
        check("idle1_count", 32'(fifo_count1), 32'(0));
    endtask

    task automatic push_word(input logic [WIDTH-1:0] d);
        int k;
        k = 0;
        do begin
            step(1'b0, 1'b1, d);
            k++;
        end while (!m_acc && k < 64);
        check("push_timeout", 32'(m_acc), 32'(1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    initial begin
        logic [WIDTH-1:0] words [5];
        int k;
        words[0] = 8'hB0; words[1] = 8'hFF; words[2] = 8'h00;
        words[3] = 8'h5A; words[4] = 8'hC3;

        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        check("rst_ser_bit", 32'(ser_bit), 32'(0));
        check("rst_count",   32'(fifo_count), 32'(0));

        push_word(8'hB0);
        idle(BPW + 4);

        for (int i = 0; i < 5; i++) push_word(words[i]);
        idle(5 * BPW + 6);

        push_word(8'hB0);
        push_word(8'h03);
        idle(2 * BPW + 4);

        for (int i = 0; i < 150; i++)
            step(1'b0, 1'($urandom_range(0, 99) < 60), WIDTH'($urandom));
        for (int i = 0; i < 150; i++)
            step(1'b0, 1'($urandom_range(0, 99) < 12), WIDTH'($urandom));
        idle(DEPTH * BPW + BPW + 4);

        // Reset on the third bit of A5 while two words wait in the FIFO
        push_word(8'hA5);
        push_word(8'h3C);
        push_word(8'h96);
        k = 0;
        while (!(m_active && m_bits.size() == BPW - 3) && k < 32) begin
            idle(1);
            k++;
        end
        check("reach_3rd_bit", 32'(m_bits.size()), 32'(BPW - 3));
        check("queued_before_rst", 32'(fifo_count), 32'(2));
        step(1'b1, 1'b0, '0);
        check("after_rst_active", 32'(ser_active), 32'(0));
        check("after_rst_count",  32'(fifo_count), 32'(0));
        idle(2 * BPW);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
